// File: rtl/sum_uart_tx_pkg.sv
// Shared types and constants for the adding UART transmitter.
// SUM_UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package sum_uart_tx_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS_NO_PARITY = 10;
  localparam int unsigned FRAME_BITS_PARITY    = 11;

`ifdef SUM_UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = FRAME_BITS_PARITY;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  localparam int unsigned FRAME_BITS = FRAME_BITS_NO_PARITY;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sum_uart_tx_baud.sv
// Bit-period counter: bit_tick marks the last enabled cycle of every bit period.
// restart holds the count at zero so the next period starts cleanly.
module sum_uart_tx_baud #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] cnt_r;

  // Count enabled cycles within the current bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (ena) begin
      if (restart || (cnt_r == LAST_CNT)) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bit_tick = ena && !restart && (cnt_r == LAST_CNT);

endmodule

// File: rtl/sum_uart_tx.sv
// Adds two bytes and sends the 8-bit sum LSB-first as a UART frame on tx.
// SUM_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module sum_uart_tx
  import sum_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] sum,
  output logic       carry
);

  state_t     state_r;
  logic [7:0] shift_r;
  logic [2:0] idx_r;
  logic       restart_s;
  logic       bit_tick_s;

  assign restart_s = (state_r == ST_IDLE);

  sum_uart_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .restart  (restart_s),
    .bit_tick (bit_tick_s)
  );

  // Frame sequencer with registered line, status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      shift_r <= 8'd0;
      idx_r   <= 3'd0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= 8'd0;
      carry   <= 1'b0;
    end else begin
      // done is a pulse, so it drops even while ena holds everything else
      done <= 1'b0;
      if (ena) begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              {carry, sum} <= {1'b0, a} + {1'b0, b};
              shift_r      <= a + b;
              idx_r        <= 3'd0;
              state_r      <= ST_START;
              busy         <= 1'b1;
              tx           <= 1'b0;
            end
          end
          ST_START: begin
            if (bit_tick_s) begin
              tx      <= shift_r[0];
              shift_r <= {1'b0, shift_r[7:1]};
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (bit_tick_s) begin
              idx_r <= idx_r + 3'd1;
              if (idx_r == 3'd7) begin
`ifdef SUM_UART_TX_PARITY_EN
                tx      <= even_parity(sum);
                state_r <= ST_PARITY;
`else
                tx      <= 1'b1;
                state_r <= ST_STOP;
`endif
              end else begin
                tx      <= shift_r[0];
                shift_r <= {1'b0, shift_r[7:1]};
              end
            end
          end
`ifdef SUM_UART_TX_PARITY_EN
          ST_PARITY: begin
            if (bit_tick_s) begin
              tx      <= 1'b1;
              state_r <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            if (bit_tick_s) begin
              tx      <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end
          default: begin
            tx      <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Scoreboard bench for sum_uart_tx with CLKS_PER_BIT=4; honours SUM_UART_TX_PARITY_EN.
module tb_sum_uart_tx;

  localparam int CPB = 4;
`ifdef SUM_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    int         cycles;
    logic       abort;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  sum_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .a     (a),
    .b     (b),
    .tx    (tx),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected tx level for every enabled busy cycle of a frame carrying s
  function automatic logic [63:0] frame_bits(input logic [7:0] s);
    logic [10:0] seq;
    logic [63:0] r;
    int n;
    r = 64'd0;
    seq = 11'd0;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = s[i];
    n = 9;
`ifdef SUM_UART_TX_PARITY_EN
    seq[9] = ^s;
    n = 10;
`endif
    seq[n] = 1'b1;
    n = n + 1;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < CPB; c++) r[k*CPB+c] = seq[k];
    return r;
  endfunction

  // Monitor: collect the frame, compare on done or on an aborted frame
  logic        prev_busy = 1'b0;
  int          busy_cyc = 0;
  int          nbits = 0;
  logic [63:0] got = 64'd0;
  exp_t        e;

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      busy_cyc = 0;
      nbits = 0;
      got = 64'd0;
    end
    if (busy === 1'b1) begin
      busy_cyc++;
      if (ena === 1'b1 && nbits < 64) begin
        got[nbits] = tx;
        nbits++;
      end
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with sum 0x%0h, required no done", sum);
      end else begin
        e = sb.pop_front();
        tests++;
        if (e.abort) begin
          fails++;
          $display("FAIL abort_frame: got done, required aborted frame without done");
        end
        check("sum", 64'(sum), 64'(e.sum));
        check("carry", 64'(carry), 64'(e.carry));
        check("busy_cycles", 64'(busy_cyc), 64'(e.cycles));
        check("bit_count", 64'(nbits), 64'(FRAME_CYC));
        check("tx_bits", got, frame_bits(e.sum));
        check("tx_idle_at_done", 64'(tx), 64'd1);
      end
    end else if (prev_busy === 1'b1 && busy === 1'b0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_abort: got busy fall without done, required none");
      end else begin
        e = sb.pop_front();
        if (!e.abort) begin
          fails++;
          $display("FAIL missing_done: got busy fall without done, required done with sum 0x%0h", e.sum);
        end
      end
    end
    prev_busy = busy;
  end

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] es,
                      input logic ec, input int cyc, input logic ab);
    exp_t x;
    @(posedge clk);
    #1;
    a = av;
    b = bv;
    start = 1'b1;
    x.sum = es;
    x.carry = ec;
    x.cycles = cyc;
    x.abort = ab;
    sb.push_back(x);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < max_cyc) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= max_cyc) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: got busy=%b after %0d cycles, required 0", busy, k);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    rst_n = 1'b1;

    // Basic frames
    send(8'h03, 8'h04, 8'h07, 1'b0, FRAME_CYC, 1'b0);
    wait_idle(200);
    send(8'hFF, 8'h01, 8'h00, 1'b1, FRAME_CYC, 1'b0);
    wait_idle(200);
    send(8'hFF, 8'hFF, 8'hFE, 1'b1, FRAME_CYC, 1'b0);
    wait_idle(200);

    // start during data bit 3 is ignored
    send(8'h03, 8'h04, 8'h07, 1'b0, FRAME_CYC, 1'b0);
    repeat (18) @(posedge clk);
    #1;
    a = 8'h10;
    b = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_sum", 64'(sum), 64'h07);
    wait_idle(200);

    // Reset during data bit 5 aborts the frame
    send(8'h55, 8'h00, 8'h55, 1'b0, FRAME_CYC, 1'b1);
    repeat (26) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx", 64'(tx), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'h12, 8'h34, 8'h46, 1'b0, FRAME_CYC, 1'b0);
    wait_idle(200);

    // ena low for 7 cycles mid-frame
    send(8'h0F, 8'h01, 8'h10, 1'b0, FRAME_CYC + 7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    ena = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    ena = 1'b1;
    wait_idle(200);

    // start held high: back-to-back frames
    @(posedge clk);
    #1;
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    begin
      exp_t x;
      x.sum = 8'h03;
      x.carry = 1'b0;
      x.cycles = FRAME_CYC;
      x.abort = 1'b0;
      sb.push_back(x);
      sb.push_back(x);
    end
    begin
      int k;
      k = 0;
      while (done !== 1'b1 && k < 200) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (k >= 200) begin
        tests++;
        fails++;
        $display("FAIL b2b_done_timeout: got no done in %0d cycles, required done", k);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_reaccept_busy", 64'(busy), 64'd1);
    check("b2b_reaccept_tx", 64'(tx), 64'd0);
    wait_idle(200);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

endmodule
